// File: rtl/id_ex_pipeline_register_pkg.sv
// Shared widths, control bundle type and bubble encodings for the ID/EX pipeline register.
package id_ex_pipeline_register_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned ALU_SEL_W     = 5;
    localparam int unsigned MEM_READ_W    = 4;
    localparam int unsigned MEM_WRITE_W   = 3;
    localparam int unsigned BRANCH_JUMP_W = 4;
    localparam int unsigned WB_SEL_W      = 2;

    localparam logic [MEM_READ_W-1:0]    MEM_READ_NONE   = '0;
    localparam logic [MEM_WRITE_W-1:0]   MEM_WRITE_NONE  = '0;
    localparam logic [BRANCH_JUMP_W-1:0] BRANCH_NONE     = '0;
    localparam logic                     REG_WRITE_NONE  = 1'b0;

    typedef struct packed {
        logic [ALU_SEL_W-1:0]     alu_sel;
        logic                     op1_sel;
        logic                     op2_sel;
        logic [MEM_READ_W-1:0]    mem_read;
        logic [MEM_WRITE_W-1:0]   mem_write;
        logic [BRANCH_JUMP_W-1:0] branch_jump;
        logic [WB_SEL_W-1:0]      wb_sel;
        logic                     reg_write;
    } ctrl_t;

endpackage

// File: rtl/sat_event_counter.sv
// Event counter that increments on INC and sticks at all-ones instead of wrapping.
module sat_event_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             INC,
    output logic [CNT_W-1:0] COUNT
);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            COUNT <= '0;
        end else if (INC && (COUNT != {CNT_W{1'b1}})) begin
            COUNT <= COUNT + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: one-cycle capture of decode results with stall hold,
// flush-to-bubble and saturating stall/flush event counters.
module id_ex_pipeline_register
    import id_ex_pipeline_register_pkg::*;
#(
    parameter int unsigned XLEN  = id_ex_pipeline_register_pkg::XLEN,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     VALID_IN,
    input  logic [XLEN-1:0]          PC_IN,
    input  logic [XLEN-1:0]          IMM_IN,
    input  logic [XLEN-1:0]          DATA1_IN,
    input  logic [XLEN-1:0]          DATA2_IN,
    input  logic [REG_ADDR_W-1:0]    RS1_IN,
    input  logic [REG_ADDR_W-1:0]    RS2_IN,
    input  logic [REG_ADDR_W-1:0]    RD_IN,
    input  logic [ALU_SEL_W-1:0]     ALU_SEL_IN,
    input  logic                     OP1_SEL_IN,
    input  logic                     OP2_SEL_IN,
    input  logic [MEM_READ_W-1:0]    MEM_READ_IN,
    input  logic [MEM_WRITE_W-1:0]   MEM_WRITE_IN,
    input  logic [BRANCH_JUMP_W-1:0] BRANCH_JUMP_IN,
    input  logic [WB_SEL_W-1:0]      WB_SEL_IN,
    input  logic                     REG_WRITE_IN,
    input  logic                     STALL,
    input  logic                     FLUSH,
    output logic                     VALID_OUT,
    output logic [XLEN-1:0]          PC_OUT,
    output logic [XLEN-1:0]          IMM_OUT,
    output logic [XLEN-1:0]          DATA1_OUT,
    output logic [XLEN-1:0]          DATA2_OUT,
    output logic [REG_ADDR_W-1:0]    RS1_OUT,
    output logic [REG_ADDR_W-1:0]    RS2_OUT,
    output logic [REG_ADDR_W-1:0]    RD_OUT,
    output logic [ALU_SEL_W-1:0]     ALU_SEL_OUT,
    output logic                     OP1_SEL_OUT,
    output logic                     OP2_SEL_OUT,
    output logic [MEM_READ_W-1:0]    MEM_READ_OUT,
    output logic [MEM_WRITE_W-1:0]   MEM_WRITE_OUT,
    output logic [BRANCH_JUMP_W-1:0] BRANCH_JUMP_OUT,
    output logic [WB_SEL_W-1:0]      WB_SEL_OUT,
    output logic                     REG_WRITE_OUT,
    output logic [CNT_W-1:0]         STALL_COUNT,
    output logic [CNT_W-1:0]         FLUSH_COUNT
);

    logic                  valid_q;
    logic [XLEN-1:0]       pc_q, imm_q, data1_q, data2_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    ctrl_t                 ctrl_d, ctrl_q;

    // An invalid slot may carry junk decode; strip anything with architectural effect.
    always_comb begin
        ctrl_d.alu_sel     = ALU_SEL_IN;
        ctrl_d.op1_sel     = OP1_SEL_IN;
        ctrl_d.op2_sel     = OP2_SEL_IN;
        ctrl_d.mem_read    = VALID_IN ? MEM_READ_IN    : MEM_READ_NONE;
        ctrl_d.mem_write   = VALID_IN ? MEM_WRITE_IN   : MEM_WRITE_NONE;
        ctrl_d.branch_jump = VALID_IN ? BRANCH_JUMP_IN : BRANCH_NONE;
        ctrl_d.wb_sel      = WB_SEL_IN;
        ctrl_d.reg_write   = VALID_IN ? REG_WRITE_IN   : REG_WRITE_NONE;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else if (FLUSH) begin
            // Bubble only clears the effect fields; data fields keep their last values.
            valid_q                <= 1'b0;
            ctrl_q.mem_read        <= MEM_READ_NONE;
            ctrl_q.mem_write       <= MEM_WRITE_NONE;
            ctrl_q.branch_jump     <= BRANCH_NONE;
            ctrl_q.reg_write       <= REG_WRITE_NONE;
        end else if (!STALL) begin
            valid_q <= VALID_IN;
            pc_q    <= PC_IN;
            imm_q   <= IMM_IN;
            data1_q <= DATA1_IN;
            data2_q <= DATA2_IN;
            rs1_q   <= RS1_IN;
            rs2_q   <= RS2_IN;
            rd_q    <= RD_IN;
            ctrl_q  <= ctrl_d;
        end
    end

    assign VALID_OUT       = valid_q;
    assign PC_OUT          = pc_q;
    assign IMM_OUT         = imm_q;
    assign DATA1_OUT       = data1_q;
    assign DATA2_OUT       = data2_q;
    assign RS1_OUT         = rs1_q;
    assign RS2_OUT         = rs2_q;
    assign RD_OUT          = rd_q;
    assign ALU_SEL_OUT     = ctrl_q.alu_sel;
    assign OP1_SEL_OUT     = ctrl_q.op1_sel;
    assign OP2_SEL_OUT     = ctrl_q.op2_sel;
    assign MEM_READ_OUT    = ctrl_q.mem_read;
    assign MEM_WRITE_OUT   = ctrl_q.mem_write;
    assign BRANCH_JUMP_OUT = ctrl_q.branch_jump;
    assign WB_SEL_OUT      = ctrl_q.wb_sel;
    assign REG_WRITE_OUT   = ctrl_q.reg_write;

    sat_event_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (STALL && !FLUSH),
        .COUNT (STALL_COUNT)
    );

    sat_event_counter #(
        .CNT_W (CNT_W)
    ) u_flush_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (FLUSH),
        .COUNT (FLUSH_COUNT)
    );

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed and randomized bench for id_ex_pipeline_register against a field-level reference model.
module tb_id_ex_pipeline_register;

    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, op1_in, op2_in, rw_in, stall, flush;
    logic [31:0] pc_in, imm_in, d1_in, d2_in;
    logic [4:0]  rs1_in, rs2_in, rd_in, alu_in;
    logic [3:0]  mr_in, bj_in;
    logic [2:0]  mw_in;
    logic [1:0]  wb_in;

    logic        valid_o, op1_o, op2_o, rw_o;
    logic [31:0] pc_o, imm_o, d1_o, d2_o;
    logic [4:0]  rs1_o, rs2_o, rd_o, alu_o;
    logic [3:0]  mr_o, bj_o;
    logic [2:0]  mw_o;
    logic [1:0]  wb_o;
    logic [CW-1:0] scnt_o, fcnt_o;

    typedef struct {
        int unsigned valid, pc, imm, d1, d2, rs1, rs2, rd, alu, op1, op2;
        int unsigned mr, mw, bj, wb, rw, scnt, fcnt;
    } model_t;

    model_t m;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_register #(
        .XLEN  (32),
        .CNT_W (CW)
    ) dut (
        .CLK             (clk),
        .RESET           (rst_n),
        .VALID_IN        (valid_in),
        .PC_IN           (pc_in),
        .IMM_IN          (imm_in),
        .DATA1_IN        (d1_in),
        .DATA2_IN        (d2_in),
        .RS1_IN          (rs1_in),
        .RS2_IN          (rs2_in),
        .RD_IN           (rd_in),
        .ALU_SEL_IN      (alu_in),
        .OP1_SEL_IN      (op1_in),
        .OP2_SEL_IN      (op2_in),
        .MEM_READ_IN     (mr_in),
        .MEM_WRITE_IN    (mw_in),
        .BRANCH_JUMP_IN  (bj_in),
        .WB_SEL_IN       (wb_in),
        .REG_WRITE_IN    (rw_in),
        .STALL           (stall),
        .FLUSH           (flush),
        .VALID_OUT       (valid_o),
        .PC_OUT          (pc_o),
        .IMM_OUT         (imm_o),
        .DATA1_OUT       (d1_o),
        .DATA2_OUT       (d2_o),
        .RS1_OUT         (rs1_o),
        .RS2_OUT         (rs2_o),
        .RD_OUT          (rd_o),
        .ALU_SEL_OUT     (alu_o),
        .OP1_SEL_OUT     (op1_o),
        .OP2_SEL_OUT     (op2_o),
        .MEM_READ_OUT    (mr_o),
        .MEM_WRITE_OUT   (mw_o),
        .BRANCH_JUMP_OUT (bj_o),
        .WB_SEL_OUT      (wb_o),
        .REG_WRITE_OUT   (rw_o),
        .STALL_COUNT     (scnt_o),
        .FLUSH_COUNT     (fcnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '{default: 0};
    endtask

    // Reference behaviour of one rising edge, using the inputs the DUT just sampled.
    task automatic model_edge();
        if (flush) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.bj = 0;
            if (m.fcnt < CMAX) m.fcnt = m.fcnt + 1;
        end else if (stall) begin
            if (m.scnt < CMAX) m.scnt = m.scnt + 1;
        end else begin
            m.valid = valid_in; m.pc = pc_in; m.imm = imm_in; m.d1 = d1_in; m.d2 = d2_in;
            m.rs1 = rs1_in; m.rs2 = rs2_in; m.rd = rd_in; m.alu = alu_in;
            m.op1 = op1_in; m.op2 = op2_in; m.wb = wb_in;
            m.mr = valid_in ? mr_in : 0;
            m.mw = valid_in ? mw_in : 0;
            m.bj = valid_in ? bj_in : 0;
            m.rw = valid_in ? rw_in : 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(valid_o), m.valid);
        chk({tag, ".pc"},    pc_o,         m.pc);
        chk({tag, ".imm"},   imm_o,        m.imm);
        chk({tag, ".d1"},    d1_o,         m.d1);
        chk({tag, ".d2"},    d2_o,         m.d2);
        chk({tag, ".rs1"},   32'(rs1_o),   m.rs1);
        chk({tag, ".rs2"},   32'(rs2_o),   m.rs2);
        chk({tag, ".rd"},    32'(rd_o),    m.rd);
        chk({tag, ".alu"},   32'(alu_o),   m.alu);
        chk({tag, ".op1"},   32'(op1_o),   m.op1);
        chk({tag, ".op2"},   32'(op2_o),   m.op2);
        chk({tag, ".mr"},    32'(mr_o),    m.mr);
        chk({tag, ".mw"},    32'(mw_o),    m.mw);
        chk({tag, ".bj"},    32'(bj_o),    m.bj);
        chk({tag, ".wb"},    32'(wb_o),    m.wb);
        chk({tag, ".rw"},    32'(rw_o),    m.rw);
        chk({tag, ".scnt"},  32'(scnt_o),  m.scnt);
        chk({tag, ".fcnt"},  32'(fcnt_o),  m.fcnt);
    endtask

    task automatic rand_inputs();
        valid_in = 1'($urandom); pc_in = $urandom; imm_in = $urandom;
        d1_in = $urandom; d2_in = $urandom;
        rs1_in = 5'($urandom); rs2_in = 5'($urandom); rd_in = 5'($urandom);
        alu_in = 5'($urandom); op1_in = 1'($urandom); op2_in = 1'($urandom);
        mr_in = 4'($urandom); mw_in = 3'($urandom); bj_in = 4'($urandom);
        wb_in = 2'($urandom); rw_in = 1'($urandom);
    endtask

    // Inputs are set at the falling edge; this advances one rising edge and checks at the next fall.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        rand_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check_model("reset");

        // Normal flow
        rst_n    = 1'b1;
        rand_inputs();
        valid_in = 1'b1; imm_in = 32'hFFFF_F800; rd_in = 5'd5; rw_in = 1'b1;
        step("load");
        chk("load.imm_const", imm_o, 32'hFFFF_F800);
        chk("load.rd_const", 32'(rd_o), 32'd5);
        chk("load.rw_const", 32'(rw_o), 32'd1);
        chk("load.valid_const", 32'(valid_o), 32'd1);

        // Stall three edges while inputs churn
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step("stall");
        end
        chk("stall.count_const", 32'(scnt_o), 32'd3);
        chk("stall.imm_frozen", imm_o, 32'hFFFF_F800);

        // Load a store, then flush with stall also high
        stall = 1'b0;
        rand_inputs();
        valid_in = 1'b1; mw_in = 3'd2;
        step("store");
        chk("store.mw_const", 32'(mw_o), 32'd2);
        stall = 1'b1; flush = 1'b1;
        rand_inputs();
        step("flush_stall");
        chk("flush.valid_const", 32'(valid_o), 32'd0);
        chk("flush.mw_const", 32'(mw_o), 32'd0);
        chk("flush.fcnt_const", 32'(fcnt_o), 32'd1);
        chk("flush.scnt_const", 32'(scnt_o), 32'd3);

        // Invalid slot strips control effects
        stall = 1'b0; flush = 1'b0;
        rand_inputs();
        valid_in = 1'b0; rw_in = 1'b1; bj_in = 4'd3;
        step("invalid");
        chk("invalid.rw_const", 32'(rw_o), 32'd0);
        chk("invalid.bj_const", 32'(bj_o), 32'd0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 5) == 0);
            step("rand");
        end

        // Asynchronous reset mid-cycle with non-zero contents
        stall = 1'b0; flush = 1'b0;
        rand_inputs();
        valid_in = 1'b1; pc_in = 32'h0000_1234; rw_in = 1'b1;
        step("pre_reset");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_model("async_reset");
        @(posedge clk);
        @(negedge clk);
        check_model("reset_held");
        rst_n = 1'b1;

        // Stall counter saturation
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            step("sat");
        end
        chk("sat.count_const", 32'(scnt_o), CMAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Pipeline register between the instruction-decode stage (register file read, immediate generation, control decode) and the execute stage of the RV32IM pipeline.
- Captures the sign/zero-extended immediate, the operand data, the register addresses, the PC and the decoded control bundle each cycle.
- Supports hold on stall and bubble insertion on flush.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- XLEN, 32, datapath width (PC, immediate, operand data)
- CNT_W, 16, width of the stall/flush event counters

Ports:
- CLK  input  1  pipeline clock; all state updates on the rising edge
- RESET  input  1  asynchronous, active-low reset; clears all state immediately
- VALID_IN  input  1  decode stage presents a real instruction this cycle
- PC_IN  input  XLEN  PC of the decoded instruction
- IMM_IN  input  XLEN  extended immediate from the immediate-select stage
- DATA1_IN  input  XLEN  register-file read data, rs1
- DATA2_IN  input  XLEN  register-file read data, rs2
- RS1_IN  input  5  rs1 address (for forwarding)
- RS2_IN  input  5  rs2 address (for forwarding)
- RD_IN  input  5  destination register address
- ALU_SEL_IN  input  5  ALU/M-unit operation select
- OP1_SEL_IN  input  1  operand-1 source select (0 = DATA1, 1 = PC)
- OP2_SEL_IN  input  1  operand-2 source select (0 = DATA2, 1 = IMM)
- MEM_READ_IN  input  4  load type (0 = no load)
- MEM_WRITE_IN  input  3  store type (0 = no store)
- BRANCH_JUMP_IN  input  4  branch/jump type (0 = none)
- WB_SEL_IN  input  2  write-back source select
- REG_WRITE_IN  input  1  register write enable
- STALL  input  1  hold current contents (hazard unit or busy M-unit)
- FLUSH  input  1  replace contents with a bubble (taken branch, jump, load-use)
- VALID_OUT, PC_OUT, IMM_OUT, DATA1_OUT, DATA2_OUT, RS1_OUT, RS2_OUT, RD_OUT, ALU_SEL_OUT, OP1_SEL_OUT, OP2_SEL_OUT, MEM_READ_OUT, MEM_WRITE_OUT, BRANCH_JUMP_OUT, WB_SEL_OUT, REG_WRITE_OUT  output  (width as matching input)  registered copies feeding execute
- STALL_COUNT  output  CNT_W  number of cycles with STALL asserted (and FLUSH not asserted)
- FLUSH_COUNT  output  CNT_W  number of cycles with FLUSH asserted

Behaviour:
- Reset (RESET = 0, asynchronous): every output is 0, counters are 0. The register holds a bubble.
- Reset release: the first capture happens on the first rising CLK edge with RESET = 1.
- Latency: exactly one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Per-edge priority is FLUSH > STALL > load:
  - FLUSH = 1: load a bubble. VALID_OUT, REG_WRITE_OUT, MEM_READ_OUT, MEM_WRITE_OUT and BRANCH_JUMP_OUT go to 0. All other fields hold their previous values. FLUSH_COUNT increments. This applies even when STALL = 1; STALL_COUNT does not increment in that case.
  - STALL = 1, FLUSH = 0: every output holds its value. STALL_COUNT increments.
  - Otherwise: all fields load from their inputs.
- VALID_IN = 0 on a load: the data fields load normally. The control-effect fields (REG_WRITE, MEM_READ, MEM_WRITE, BRANCH_JUMP) are forced to 0, so any field not being 0 implies VALID_OUT = 1.
- Counters: saturate at all-ones and never wrap.
- No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush: outputs clear immediately and the counters reset.

Decomposition:
- Shared package holds:
  - XLEN
  - control-field widths (ALU_SEL 5, MEM_READ 4, MEM_WRITE 3, BRANCH_JUMP 4, WB_SEL 2)
  - the bubble encoding constants (zero for each control-effect field)
- One natural sub-module, sat_event_counter: parameter CNT_W; inputs CLK, RESET, INC; output COUNT. Instantiated twice.

Test Plan:
- Reset: assert RESET = 0 mid-cycle while outputs are non-zero -> all outputs and both counters read 0 before the next edge.
- Normal flow: VALID_IN = 1, IMM_IN = 0xFFFFF800, RD_IN = 5, REG_WRITE_IN = 1 -> after one edge IMM_OUT = 0xFFFFF800, RD_OUT = 5, REG_WRITE_OUT = 1, VALID_OUT = 1.
- Stall: STALL = 1 for 3 edges while the inputs change -> outputs stay frozen at the pre-stall values and STALL_COUNT = 3.
- Flush vs stall: STALL = 1 and FLUSH = 1 on the same edge, with MEM_WRITE_OUT = 2 beforehand -> VALID_OUT = 0, MEM_WRITE_OUT = 0, PC_OUT unchanged, FLUSH_COUNT = 1, STALL_COUNT unchanged.
- Invalid instruction: VALID_IN = 0 with REG_WRITE_IN = 1 and BRANCH_JUMP_IN = 3 -> REG_WRITE_OUT = 0 and BRANCH_JUMP_OUT = 0 after the edge.
- Saturation: CNT_W = 4, STALL = 1 for 20 edges -> STALL_COUNT = 15 and stays at 15.
